// File: rtl/ahb_slave_mux_pkg.sv
// Shared AHB-Lite codes, data-phase owner encoding and default memory map for ahb_slave_mux.
package ahb_slave_mux_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_SLV = 4;

  // HTRANS codes
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP codes
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default memory map
  localparam logic [ADDR_W-1:0] MAP_S0_BASE = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] MAP_S0_MASK = 32'hE000_0000;
  localparam logic [ADDR_W-1:0] MAP_S1_BASE = 32'h2000_0000;
  localparam logic [ADDR_W-1:0] MAP_S1_MASK = 32'hE000_0000;
  localparam logic [ADDR_W-1:0] MAP_S2_BASE = 32'h4000_0000;
  localparam logic [ADDR_W-1:0] MAP_S2_MASK = 32'hF000_0000;
  localparam logic [ADDR_W-1:0] MAP_S3_BASE = 32'h5000_0000;
  localparam logic [ADDR_W-1:0] MAP_S3_MASK = 32'hF000_0000;

  // Data-phase owner
  typedef enum logic [2:0] {
    DSEL_S0   = 3'd0,
    DSEL_S1   = 3'd1,
    DSEL_S2   = 3'd2,
    DSEL_S3   = 3'd3,
    DSEL_DEF  = 3'd4,
    DSEL_NONE = 3'd5
  } dsel_e;

  // Default slave error FSM states
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR response for transfers to unmapped space.
module ahb_default_slave
  import ahb_slave_mux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  output logic hready,
  output logic hresp
);

  ds_state_e state_q, state_d;
  logic      hready_d;
  logic      hresp_d;

  // Next state; outputs decoded from the next state so they come straight off flops
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (accept) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = accept ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    hready_d = (state_d != DS_ERR1);
    hresp_d  = (state_d != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;
  end

  // State and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DS_IDLE;
      hready  <= 1'b1;
      hresp   <= HRESP_OKAY;
    end else begin
      state_q <= state_d;
      hready  <= hready_d;
      hresp   <= hresp_d;
    end
  end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite address decoder and response mux for four slaves plus a default slave.
// Build option: AHB_MUX_DEFAULT_ERR_EN enables the two-cycle ERROR default slave;
// without it unmapped transfers complete as zero-wait OKAY with zero read data.
module ahb_slave_mux
  import ahb_slave_mux_pkg::*;
#(
  parameter logic [31:0] S0_BASE = MAP_S0_BASE,
  parameter logic [31:0] S0_MASK = MAP_S0_MASK,
  parameter logic [31:0] S1_BASE = MAP_S1_BASE,
  parameter logic [31:0] S1_MASK = MAP_S1_MASK,
  parameter logic [31:0] S2_BASE = MAP_S2_BASE,
  parameter logic [31:0] S2_MASK = MAP_S2_MASK,
  parameter logic [31:0] S3_BASE = MAP_S3_BASE,
  parameter logic [31:0] S3_MASK = MAP_S3_MASK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           haddr,
  input  logic [1:0]                  htrans,
  output logic                        hready,
  output logic [DATA_W-1:0]           hrdata,
  output logic                        hresp,
  output logic [NUM_SLV-1:0]          s_hsel,
  input  logic [NUM_SLV*DATA_W-1:0]   s_hrdata,
  input  logic [NUM_SLV-1:0]          s_hready_out,
  input  logic [NUM_SLV-1:0]          s_hresp
);

  dsel_e dsel_q, dsel_d;
  logic  unmapped;
  logic  def_hready;
  logic  def_hresp;
  logic  unused_htrans0;

  // Only htrans[1] distinguishes active transfers from IDLE/BUSY
  assign unused_htrans0 = htrans[0];

  // Address decode, lowest index wins on overlap; independent of htrans
  always_comb begin
    s_hsel = '0;
    dsel_d = DSEL_NONE;
    if ((haddr & S0_MASK) == S0_BASE) begin
      s_hsel = 4'b0001;
      dsel_d = DSEL_S0;
    end else if ((haddr & S1_MASK) == S1_BASE) begin
      s_hsel = 4'b0010;
      dsel_d = DSEL_S1;
    end else if ((haddr & S2_MASK) == S2_BASE) begin
      s_hsel = 4'b0100;
      dsel_d = DSEL_S2;
    end else if ((haddr & S3_MASK) == S3_BASE) begin
      s_hsel = 4'b1000;
      dsel_d = DSEL_S3;
    end else if (htrans[1]) begin
      dsel_d = DSEL_DEF;
    end
  end

  assign unmapped = (dsel_d == DSEL_DEF);

  // Data-phase owner advances only when the current data phase completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsel_q <= DSEL_NONE;
    end else if (hready) begin
      dsel_q <= dsel_d;
    end
  end

`ifdef AHB_MUX_DEFAULT_ERR_EN
  ahb_default_slave u_default_slave (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (unmapped & hready),
    .hready (def_hready),
    .hresp  (def_hresp)
  );
`else
  logic unused_unmapped;
  assign unused_unmapped = unmapped;
  assign def_hready      = 1'b1;
  assign def_hresp       = HRESP_OKAY;
`endif

  // Response mux driven by the registered data-phase owner
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (dsel_q)
      DSEL_S0: begin
        hrdata = s_hrdata[0*DATA_W +: DATA_W];
        hready = s_hready_out[0];
        hresp  = s_hresp[0];
      end
      DSEL_S1: begin
        hrdata = s_hrdata[1*DATA_W +: DATA_W];
        hready = s_hready_out[1];
        hresp  = s_hresp[1];
      end
      DSEL_S2: begin
        hrdata = s_hrdata[2*DATA_W +: DATA_W];
        hready = s_hready_out[2];
        hresp  = s_hresp[2];
      end
      DSEL_S3: begin
        hrdata = s_hrdata[3*DATA_W +: DATA_W];
        hready = s_hready_out[3];
        hresp  = s_hresp[3];
      end
      DSEL_DEF: begin
        hready = def_hready;
        hresp  = def_hresp;
      end
      default: begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
      end
    endcase
  end

endmodule
